// File: rtl/mux8_scan_capture.sv
// Scans an external 8:1 mux one select at a time and assembles the captured byte.
// Optional y/w consistency checking is enabled with `define MUX_CHECK_W_EN.
module mux8_scan_capture #(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y,
    input  logic       w,
    input  logic       ack,
    output logic       g,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic [7:0] data,
    output logic       valid,
    output logic       busy,
    output logic       err
);

    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] sel, sel_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] cap, cap_nxt;
    logic [7:0] data_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            cnt   <= '0;
            cap   <= '0;
            data  <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
            cap   <= cap_nxt;
            data  <= data_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = sel;
        cnt_nxt   = cnt;
        cap_nxt   = cap;
        data_nxt  = data;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SETTLE;
                    sel_nxt   = '0;
                    cnt_nxt   = SETTLE_LD;
                    cap_nxt   = '0;
                end
            end
            SETTLE: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                cap_nxt[sel] = y;
                if (sel != 3'd7) begin
                    sel_nxt   = sel + 3'd1;
                    cnt_nxt   = SETTLE_LD;
                    state_nxt = SETTLE;
                end else begin
                    // Bit 7 lands in cap on this same edge, so data takes the updated value.
                    state_nxt = DONE;
                    sel_nxt   = '0;
                    data_nxt  = cap_nxt;
                end
            end
            DONE: begin
                if (ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy      = (state == SETTLE) || (state == SAMPLE);
    assign g         = ~busy;
    assign valid     = (state == DONE);
    assign {c, b, a} = sel;

`ifdef MUX_CHECK_W_EN
    logic err_q;

    // Sticky per frame; a healthy mux always presents w as the complement of y.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state == IDLE && start) begin
            err_q <= 1'b0;
        end else if (state == SAMPLE && w == y) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    logic unused_w;
    assign unused_w = w;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_mux8_scan_capture.sv
// Directed bench for mux8_scan_capture: default instance plus a SETTLE_CYC=1 instance.
module tb_mux8_scan_capture;

`ifdef MUX_CHECK_W_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, ack, y, w, w_fault;
    logic       g, a, b, c, valid, busy, err;
    logic [7:0] data, mux_in;

    logic       start1, ack1, y1, w1;
    logic       g1, a1, b1, c1, valid1, busy1, err1;
    logic [7:0] data1, mux_in1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // External mux models: output forced low while not strobed, w is the complement unless faulted.
    assign y  = g ? 1'b0 : mux_in[{c, b, a}];
    assign w  = (w_fault && {c, b, a} == 3'd6) ? y : ~y;
    assign y1 = g1 ? 1'b0 : mux_in1[{c1, b1, a1}];
    assign w1 = ~y1;

    mux8_scan_capture dut (
        .clk(clk), .rst(rst), .start(start), .y(y), .w(w), .ack(ack),
        .g(g), .a(a), .b(b), .c(c), .data(data), .valid(valid), .busy(busy), .err(err)
    );

    mux8_scan_capture #(.SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .y(y1), .w(w1), .ack(ack1),
        .g(g1), .a(a1), .b(b1), .c(c1), .data(data1), .valid(valid1), .busy(busy1), .err(err1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one default-instance frame from start to the DONE cycle (cycle 25).
    task automatic scan_frame(input logic [7:0] pat, input logic [7:0] prev, input logic exp_err,
                              input int start_at, input int ack_at);
        mux_in = pat;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check("busy_on", 32'(busy), 1);
        check("g_low", 32'(g), 0);
        check("err_clr", 32'(err), 0);
        for (int k = 1; k <= 24; k++) begin
            check("sel", 32'({c, b, a}), 32'((k - 1) / 3));
            check("valid_lo", 32'(valid), 0);
            check("data_hold", 32'(data), 32'(prev));
            start = (k == start_at);
            ack   = (k == ack_at);
            tick();
        end
        start = 1'b0;
        ack   = 1'b0;
        check("valid_25", 32'(valid), 1);
        check("data", 32'(data), 32'(pat));
        check("err", 32'(err), 32'(exp_err));
        check("g_done", 32'(g), 1);
        check("busy_done", 32'(busy), 0);
        check("sel_done", 32'({c, b, a}), 0);
    endtask

    task automatic ack_frame(input logic [7:0] pat);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("valid_off", 32'(valid), 0);
        check("g_idle", 32'(g), 1);
        check("busy_idle", 32'(busy), 0);
        check("data_keep", 32'(data), 32'(pat));
    endtask

    task automatic scan_frame1(input logic [7:0] pat, input logic [7:0] prev);
        mux_in1 = pat;
        start1  = 1'b1;
        tick();
        start1  = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            check("s1_sel", 32'({c1, b1, a1}), 32'((k - 1) / 2));
            check("s1_valid_lo", 32'(valid1), 0);
            check("s1_data_hold", 32'(data1), 32'(prev));
            tick();
        end
        check("s1_valid_17", 32'(valid1), 1);
        check("s1_data", 32'(data1), 32'(pat));
        check("s1_err", 32'(err1), 0);
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        check("s1_valid_off", 32'(valid1), 0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; start = 1'b0; ack = 1'b0; w_fault = 1'b0; mux_in = '0;
        start1 = 1'b0; ack1 = 1'b0; mux_in1 = '0;
        tick();
        check("rst_g", 32'(g), 1);
        check("rst_sel", 32'({c, b, a}), 0);
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_valid1", 32'(valid1), 0);
        rst = 1'b0;
        tick();

        // Basic frame, then hold valid with ack low.
        scan_frame(8'hA5, 8'h00, 1'b0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 32'(valid), 1);
            check("hold_data", 32'(data), 32'hA5);
        end
        ack_frame(8'hA5);

        // ack in IDLE does nothing.
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("idle_ack_busy", 32'(busy), 0);
        check("idle_ack_valid", 32'(valid), 0);

        // start mid-scan and start+ack in DONE are both ignored; ack mid-scan ignored.
        scan_frame(8'h5A, 8'hA5, 1'b0, 5, 7);
        start = 1'b1;
        ack   = 1'b1;
        tick();
        start = 1'b0;
        ack   = 1'b0;
        check("sa_valid", 32'(valid), 0);
        check("sa_busy", 32'(busy), 0);
        repeat (3) tick();
        check("no_restart", 32'(busy), 0);
        check("no_restart_g", 32'(g), 1);

        // Reset mid-scan at cycle 12 (sel=3).
        mux_in = 8'h77;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (11) tick();
        check("abort_sel", 32'({c, b, a}), 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_valid", 32'(valid), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_g", 32'(g), 1);
        check("abort_sel0", 32'({c, b, a}), 0);
        check("abort_data", 32'(data), 0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen = seen | valid | busy;
        end
        check("abort_quiet", 32'(seen), 0);
        scan_frame(8'h3C, 8'h00, 1'b0, 0, 0);
        ack_frame(8'h3C);

        // w equal to y on input 6 only.
        w_fault = 1'b1;
        scan_frame(8'hC3, 8'h3C, CHK, 0, 0);
        w_fault = 1'b0;
        ack_frame(8'hC3);
        scan_frame(8'h96, 8'hC3, 1'b0, 0, 0);
        ack_frame(8'h96);

        // SETTLE_CYC=1 back-to-back frames.
        scan_frame1(8'hFF, 8'h00);
        scan_frame1(8'h00, 8'hFF);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mux8_scan_capture.md
MUX8_SCAN_CAPTURE -- requirements
Module: mux8_scan_capture

Interface
REQ-001 The block SHALL have parameter SETTLE_CYC, default 2, giving the number of settle cycles after each select change before sampling; legal range is 1..15.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock, with all state updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: scan request, sampled only in IDLE.
REQ-005 The block SHALL have port y, input, 1 bit: true data output from the external 8:1 mux.
REQ-006 The block SHALL have port w, input, 1 bit: complement data output from the external mux.
REQ-007 The block SHALL have port ack, input, 1 bit: consumer acknowledge of a completed byte.
REQ-008 The block SHALL have port g, output, 1 bit: active-low strobe driven to the external mux.
REQ-009 The block SHALL have ports a, b, c, output, 1 bit each: mux select lines, with a as LSB and c as MSB.
REQ-010 The block SHALL have port data, output, 8 bits: captured byte, where data[i] is the value of mux input i.
REQ-011 The block SHALL have port valid, output, 1 bit: data holds a complete frame awaiting ack.
REQ-012 The block SHALL have port busy, output, 1 bit: a scan is in progress (SETTLE or SAMPLE).
REQ-013 The block SHALL have port err, output, 1 bit: y/w consistency error for the current frame.

Function
REQ-014 The FSM SHALL have states IDLE, SETTLE, SAMPLE and DONE, with a 3-bit select counter sel ({c,b,a}=sel) and a 4-bit settle counter.
REQ-015 In IDLE: g=1, sel=0, busy=0, valid=0; start=1 SHALL cause a transition to SETTLE on the next edge with sel=0, g=0, settle counter=SETTLE_CYC, and the capture register and err cleared.
REQ-016 SETTLE SHALL last exactly SETTLE_CYC cycles with g=0 and sel stable, then transition to SAMPLE.
REQ-017 SAMPLE SHALL last exactly one cycle: the internal capture bit [sel] <= y; if sel<7, sel increments and the FSM returns to SETTLE with the counter reloaded; if sel==7, it goes to DONE.
REQ-018 On entry to DONE, data SHALL load from the capture register in the same edge, valid=1, g=1, busy=0, and sel SHALL return to 0.
REQ-019 data SHALL hold its previous value throughout a scan and change only on DONE entry or reset.
REQ-020 Latency: with start sampled at cycle 0, valid SHALL rise at cycle 8*(SETTLE_CYC+1)+1, which is 25 at the default.
REQ-021 In DONE, valid SHALL remain 1 until ack=1; ack=1 SHALL cause a transition to IDLE on the next edge, with valid dropping there.
REQ-022 start SHALL be ignored in SETTLE, SAMPLE and DONE, including start and ack asserted in the same DONE cycle; start must be re-presented in IDLE.
REQ-023 ack SHALL be ignored outside DONE.
REQ-024 g SHALL be 0 only in SETTLE and SAMPLE, so the external mux is strobed only during a scan.

Reset
REQ-025 rst=1 at any edge SHALL force IDLE, g=1, a=b=c=0, data=8'h00, valid=0, busy=0, err=0, settle counter=0, and the capture register cleared, including mid-scan and in DONE.
REQ-026 rst SHALL have priority over start and ack; a partial frame aborted by rst SHALL never produce valid.

Configuration
REQ-027 The macro MUX_CHECK_W_EN SHALL control y/w consistency checking.
REQ-028 With MUX_CHECK_W_EN defined, each SAMPLE cycle with w==y SHALL set err sticky for the frame; err is visible from the following cycle, remains through DONE, is cleared on the next IDLE->SETTLE transition, and does not abort the scan or suppress valid.
REQ-029 Without MUX_CHECK_W_EN, err SHALL be constant 0 and w SHALL be unused.

Verification
REQ-030 Default SETTLE_CYC, mux model inputs 8'hA5, start pulsed one cycle -> sel steps 0..7 with each value held 3 cycles, valid rises at cycle 25, data=8'hA5, err=0.
REQ-031 valid held with ack low for 10 cycles, then ack pulsed -> data stays stable the whole time, valid drops the cycle after ack, and state returns to IDLE with g=1.
REQ-032 start re-asserted at scan cycle 5 and in the DONE cycle together with ack -> neither is accepted, and no new scan starts until start is asserted in IDLE.
REQ-033 rst asserted at scan cycle 12 (sel=3), then mux inputs 8'h3C and a new start -> outputs reset at the next edge, valid never rises for the aborted frame, and the next frame yields data=8'h3C.
REQ-034 MUX_CHECK_W_EN defined, w forced equal to y for input 6 only -> err=1 with valid, data still correct; the next clean frame starts with err=0. Without the macro, err stays 0.
REQ-035 SETTLE_CYC=1, inputs 8'hFF then 8'h00 on back-to-back frames -> valid at cycle 17 of each frame, with data 8'hFF then 8'h00.
